// File: rtl/paddle_pkg.sv
// Shared types and default constants for the paddle renderer.
package paddle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_DRAW,
        ST_FULL,
        ST_DONE
    } state_e;

    localparam int unsigned DEFAULT_SCREEN_W = 120;
    localparam int unsigned DEFAULT_ROW      = 112;

    localparam int unsigned POS_W   = 9;
    localparam int unsigned X_W     = 8;
    localparam int unsigned Y_W     = 7;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned SPAN_W  = 10;

    localparam logic [COLOR_W-1:0] DEFAULT_FG_COLOR = 3'b001;
    localparam logic [COLOR_W-1:0] DEFAULT_BG_COLOR = 3'b000;

endpackage

// File: rtl/paddle_span.sv
// Combinational clamp of a paddle centre position to its on-screen column span.
module paddle_span
    import paddle_pkg::*;
#(
    parameter int unsigned SCREEN_W = DEFAULT_SCREEN_W,
    parameter int unsigned PAD_W    = 7
) (
    input  logic [POS_W-1:0] i_position,
    output logic [X_W-1:0]   o_left,
    output logic [X_W-1:0]   o_right
);

    localparam int unsigned              HALF   = (PAD_W - 1) / 2;
    localparam logic signed [SPAN_W-1:0] HALF_S = SPAN_W'(HALF);
    localparam logic signed [SPAN_W-1:0] MAX_X  = SPAN_W'(SCREEN_W - 1);

    logic signed [SPAN_W-1:0] w_pos;
    logic signed [SPAN_W-1:0] w_left;
    logic signed [SPAN_W-1:0] w_right;

    // Signed arithmetic so a centre near column 0 goes negative instead of wrapping.
    always_comb begin
        w_pos = signed'(SPAN_W'(i_position));
        if (w_pos > MAX_X) begin
            w_pos = MAX_X;
        end
        w_left  = w_pos - HALF_S;
        w_right = w_pos + HALF_S;
        if (w_left[SPAN_W-1]) begin
            w_left = '0;
        end
        if (w_right > MAX_X) begin
            w_right = MAX_X;
        end
    end

    assign o_left  = X_W'(w_left);
    assign o_right = X_W'(w_right);

endmodule

// File: rtl/paddle_renderer.sv
// Paddle drawing engine: streams single-pixel framebuffer writes for an
// incremental (erase stale columns, then draw) or full-band paddle redraw.
module paddle_renderer
    import paddle_pkg::*;
#(
    parameter int unsigned         SCREEN_W = DEFAULT_SCREEN_W,
    parameter int unsigned         PAD_W    = 7,
    parameter int unsigned         PAD_H    = 3,
    parameter int unsigned         ROW      = DEFAULT_ROW,
    parameter logic [COLOR_W-1:0]  FG_COLOR = DEFAULT_FG_COLOR,
    parameter logic [COLOR_W-1:0]  BG_COLOR = DEFAULT_BG_COLOR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               full_redraw,
    input  logic [POS_W-1:0]   position,
    output logic               busy,
    output logic               done,
    output logic               plot,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color
);

    localparam int unsigned          ROW_W    = (PAD_H > 1) ? $clog2(PAD_H) : 1;
    localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(PAD_H - 1);
    localparam logic [X_W-1:0]       LAST_COL = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]       ROW_Y    = Y_W'(ROW);

    state_e             r_state;
    logic [X_W-1:0]     r_col;
    logic [ROW_W-1:0]   r_row;
    logic [X_W-1:0]     r_new_left;
    logic [X_W-1:0]     r_new_right;
    logic [X_W-1:0]     r_old_left;
    logic [X_W-1:0]     r_old_right;
    logic               r_old_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_plot;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [COLOR_W-1:0] r_color;

    state_e             w_state_n;
    logic [X_W-1:0]     w_col_n;
    logic [ROW_W-1:0]   w_row_n;
    logic [X_W-1:0]     w_span_left;
    logic [X_W-1:0]     w_span_right;
    logic [X_W-1:0]     w_left_use;
    logic [X_W-1:0]     w_right_use;
    logic               w_last_row;
    logic               w_cur_in;
    logic               w_nxt_in;
    logic               w_busy_n;
    logic               w_done_n;
    logic               w_plot_n;
    logic [X_W-1:0]     w_x_n;
    logic [Y_W-1:0]     w_y_n;
    logic [COLOR_W-1:0] w_color_n;

    paddle_span #(
        .SCREEN_W (SCREEN_W),
        .PAD_W    (PAD_W)
    ) u_span (
        .i_position (position),
        .o_left     (w_span_left),
        .o_right    (w_span_right)
    );

    // State, scan position and the registered pixel outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_new_left  <= '0;
            r_new_right <= '0;
            r_old_left  <= '0;
            r_old_right <= '0;
            r_old_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_plot      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_color     <= '0;
        end else begin
            r_state <= w_state_n;
            r_col   <= w_col_n;
            r_row   <= w_row_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_plot  <= w_plot_n;
            r_x     <= w_x_n;
            r_y     <= w_y_n;
            r_color <= w_color_n;
            if (r_state == ST_IDLE && start) begin
                r_new_left  <= w_span_left;
                r_new_right <= w_span_right;
            end
            if (r_state == ST_DONE) begin
                r_old_left  <= r_new_left;
                r_old_right <= r_new_right;
                r_old_valid <= 1'b1;
            end
        end
    end

    // Next scan position, then the pixel that position presents next cycle.
    always_comb begin
        w_state_n   = r_state;
        w_col_n     = r_col;
        w_row_n     = r_row;
        w_left_use  = (r_state == ST_IDLE) ? w_span_left  : r_new_left;
        w_right_use = (r_state == ST_IDLE) ? w_span_right : r_new_right;
        w_last_row  = (r_row == LAST_ROW);
        w_cur_in    = (r_col >= r_new_left) && (r_col <= r_new_right);
        w_busy_n    = 1'b0;
        w_done_n    = 1'b0;
        w_plot_n    = 1'b0;
        w_x_n       = '0;
        w_y_n       = '0;
        w_color_n   = '0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_row_n = '0;
                    if (full_redraw) begin
                        w_state_n = ST_FULL;
                        w_col_n   = '0;
                    end else if (r_old_valid) begin
                        w_state_n = ST_ERASE;
                        w_col_n   = r_old_left;
                    end else begin
                        w_state_n = ST_DRAW;
                        w_col_n   = w_span_left;
                    end
                end
            end
            ST_ERASE: begin
                // Columns the new paddle will cover cost one idle cycle, not PAD_H.
                if (w_cur_in || w_last_row) begin
                    w_row_n = '0;
                    if (r_col == r_old_right) begin
                        w_state_n = ST_DRAW;
                        w_col_n   = r_new_left;
                    end else begin
                        w_col_n = r_col + X_W'(1);
                    end
                end else begin
                    w_row_n = r_row + ROW_W'(1);
                end
            end
            ST_DRAW: begin
                if (w_last_row) begin
                    w_row_n = '0;
                    if (r_col == r_new_right) begin
                        w_state_n = ST_DONE;
                    end else begin
                        w_col_n = r_col + X_W'(1);
                    end
                end else begin
                    w_row_n = r_row + ROW_W'(1);
                end
            end
            ST_FULL: begin
                if (w_last_row) begin
                    w_row_n = '0;
                    if (r_col == LAST_COL) begin
                        w_state_n = ST_DONE;
                    end else begin
                        w_col_n = r_col + X_W'(1);
                    end
                end else begin
                    w_row_n = r_row + ROW_W'(1);
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        w_nxt_in = (w_col_n >= w_left_use) && (w_col_n <= w_right_use);

        case (w_state_n)
            ST_ERASE: begin
                w_busy_n  = 1'b1;
                w_plot_n  = !w_nxt_in;
                w_x_n     = w_col_n;
                w_y_n     = ROW_Y + Y_W'(w_row_n);
                w_color_n = BG_COLOR;
            end
            ST_DRAW: begin
                w_busy_n  = 1'b1;
                w_plot_n  = 1'b1;
                w_x_n     = w_col_n;
                w_y_n     = ROW_Y + Y_W'(w_row_n);
                w_color_n = FG_COLOR;
            end
            ST_FULL: begin
                w_busy_n  = 1'b1;
                w_plot_n  = 1'b1;
                w_x_n     = w_col_n;
                w_y_n     = ROW_Y + Y_W'(w_row_n);
                w_color_n = w_nxt_in ? FG_COLOR : BG_COLOR;
            end
            ST_DONE: begin
                w_done_n = 1'b1;
            end
            default: begin
                w_busy_n = 1'b0;
            end
        endcase
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign plot  = r_plot;
    assign x     = r_x;
    assign y     = r_y;
    assign color = r_color;

endmodule

// File: tb/tb_paddle_renderer.sv
// Scoreboard bench for paddle_renderer: table of redraw requests plus reset corner cases.
module tb_paddle_renderer;

    localparam int SW   = 120;
    localparam int PH   = 3;
    localparam int ROWY = 112;
    localparam logic [2:0] FG = 3'b001;
    localparam logic [2:0] BG = 3'b000;

    typedef struct {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] color;
        logic       busy;
        logic       done;
        bit         chk_x;
        bit         chk_yc;
    } exp_t;

    typedef struct {
        bit full;
        int pos;
        int l;
        int r;
        int fg;
        int bg;
        int cyc;
        int inject;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       full_redraw;
    logic [8:0] position;
    logic       busy;
    logic       done;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;

    int   checks;
    int   failures;
    exp_t q[$];
    vec_t tbl[10];
    bit   tb_old_valid;
    int   tb_old_l;
    int   tb_old_r;

    paddle_renderer dut (
        .clock       (clk),
        .reset       (rst_n),
        .start       (start),
        .full_redraw (full_redraw),
        .position    (position),
        .busy        (busy),
        .done        (done),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .color       (color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_pix(input logic p, input int cx, input int r, input logic [2:0] c, input bit yc);
        exp_t e;
        e.plot   = p;
        e.x      = 8'(cx);
        e.y      = 7'(ROWY + r);
        e.color  = c;
        e.busy   = 1'b1;
        e.done   = 1'b0;
        e.chk_x  = 1'b1;
        e.chk_yc = yc;
        q.push_back(e);
    endtask

    // Expected pixel stream built from the redraw rules, one record per cycle.
    task automatic gen_expected(input bit full, input int l, input int r);
        exp_t e;
        if (full) begin
            for (int c = 0; c < SW; c++)
                for (int rr = 0; rr < PH; rr++)
                    push_pix(1'b1, c, rr, (c >= l && c <= r) ? FG : BG, 1'b1);
        end else begin
            if (tb_old_valid) begin
                for (int c = tb_old_l; c <= tb_old_r; c++) begin
                    if (c < l || c > r) begin
                        for (int rr = 0; rr < PH; rr++) push_pix(1'b1, c, rr, BG, 1'b1);
                    end else begin
                        push_pix(1'b0, c, 0, BG, 1'b0);
                    end
                end
            end
            for (int c = l; c <= r; c++)
                for (int rr = 0; rr < PH; rr++) push_pix(1'b1, c, rr, FG, 1'b1);
        end
        e = '{plot: 1'b0, x: 8'd0, y: 7'd0, color: 3'd0, busy: 1'b0, done: 1'b1,
              chk_x: 1'b0, chk_yc: 1'b0};
        q.push_back(e);
    endtask

    task automatic run_txn(input string name, input vec_t v);
        int   n;
        int   done_at;
        int   nfg;
        int   nbg;
        bit   ok;
        exp_t e;
        gen_expected(v.full, v.l, v.r);
        @(negedge clk);
        start = 1'b1; full_redraw = v.full; position = 9'(v.pos);
        @(negedge clk);
        start = 1'b0; full_redraw = 1'b0; position = 9'd0;
        n = 0; done_at = -1; nfg = 0; nbg = 0;
        while (q.size() > 0) begin
            if (n == v.inject) begin
                start = 1'b1; full_redraw = 1'b1; position = 9'd10;
            end else begin
                start = 1'b0; full_redraw = 1'b0; position = 9'd0;
            end
            e  = q.pop_front();
            ok = (plot === e.plot) && (busy === e.busy) && (done === e.done)
                 && (!e.chk_x || x === e.x)
                 && (!e.chk_yc || (y === e.y && color === e.color));
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s cyc%0d actual plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d required plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d",
                         name, n + 1, plot, busy, done, x, y, color,
                         e.plot, e.busy, e.done, e.x, e.y, e.color);
            end
            if (plot === 1'b1) begin
                if (color === FG) nfg++;
                else if (color === BG) nbg++;
            end
            if (done === 1'b1 && done_at < 0) done_at = n + 1;
            n++;
            @(negedge clk);
        end
        start = 1'b0; full_redraw = 1'b0; position = 9'd0;
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        chk({name, "_idle_done"}, 32'(done), 32'd0);
        chk({name, "_done_cycle"}, 32'(done_at), 32'(v.cyc));
        chk({name, "_fg_plots"}, 32'(nfg), 32'(v.fg));
        chk({name, "_bg_plots"}, 32'(nbg), 32'(v.bg));
        tb_old_valid = 1'b1; tb_old_l = v.l; tb_old_r = v.r;
    endtask

    initial begin
        vec_t v;
        checks = 0; failures = 0;
        tb_old_valid = 1'b0; tb_old_l = 0; tb_old_r = 0;
        start = 1'b0; full_redraw = 1'b0; position = 9'd0;

        //             full pos  l    r    fg  bg   cyc  inject
        tbl[0] = '{1'b0, 60,  57,  63,  21, 0,   22,  -1};
        tbl[1] = '{1'b0, 62,  59,  65,  21, 6,   33,  -1};
        tbl[2] = '{1'b0, 0,   0,   3,   12, 21,  34,  -1};
        tbl[3] = '{1'b0, 200, 116, 119, 12, 12,  25,  -1};
        tbl[4] = '{1'b1, 60,  57,  63,  21, 339, 361, -1};
        tbl[5] = '{1'b0, 61,  58,  64,  21, 3,   31,  -1};
        tbl[6] = '{1'b0, 119, 116, 119, 12, 21,  34,  -1};
        tbl[7] = '{1'b0, 3,   0,   6,   21, 12,  34,  -1};
        tbl[8] = '{1'b0, 511, 116, 119, 12, 21,  34,  -1};
        tbl[9] = '{1'b0, 118, 115, 119, 15, 0,   20,  3};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_color", 32'(color), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset in the middle of a DRAW pass.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tb_old_valid = 1'b0;
        @(negedge clk);
        start = 1'b1; position = 9'd30;
        @(negedge clk);
        start = 1'b0; position = 9'd0;
        repeat (4) @(negedge clk);
        chk("mid_draw_busy", 32'(busy), 32'd1);
        chk("mid_draw_plot", 32'(plot), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_plot", 32'(plot), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_x", 32'(x), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        v = '{1'b0, 60, 57, 63, 21, 0, 22, -1};
        run_txn("post_rst", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
